spi_txn_arbiter: RTL and testbench

- Shares one SPI master transaction engine between NUM_REQ requesters, each owning one active-low chip select.
- Round-robin arbitration; sequences CS setup, the one-cycle start pulse, the done wait with watchdog timeout, and the CS-high gap between frames.
- Returns the received 16-bit word to the granted requester.
- Sits between system-side clients and the SPI master.

---
 rtl/spi_arb_pkg.sv | 22 ++
 rtl/spi_txn_arbiter_rr.sv | 28 ++
 rtl/spi_txn_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
// The state encoding is fixed so that downstream debug tooling can decode it.
package spi_arb_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        WAIT  = 2'b10,
        GAP   = 2'b11
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin picker: first set request above the pointer, wrapping.
// The pointer register itself lives in the parent.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the farthest candidate to the nearest so the nearest set
    // request is the last one written and wins without a found flag.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(pointer) + k) % NUM_REQ]) begin
                grant = NUM_REQ'(1) << ((int'(pointer) + k) % NUM_REQ);
                idx   = IDX_W'((int'(pointer) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master engine between NUM_REQ requesters: round-robin grant,
// CS setup, start pulse, done wait with watchdog, and CS-high gap between frames.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SETUP_CYCLES   = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      CLK_IN,
    input  logic                      RST_N,
    input  logic                      EN,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_TxData,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RSP_RxData,
    output logic                      RSP_Valid,
    output logic                      RSP_Err,
    output logic                      BUSY,
    output logic                      M_StartFlag,
    output logic [DATA_W-1:0]         M_TxData,
    input  logic [DATA_W-1:0]         M_RxData,
    input  logic                      M_SPI_Done,
    output logic [NUM_REQ-1:0]        ChipSel_N
);

    localparam int IDX_W   = clog2(NUM_REQ);
    localparam int MAX_SG  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int CNT_W   = clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                done_q;
    logic                done_rise;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (REQ),
        .pointer (ptr_q),
        .grant   (arb_gnt),
        .idx     (arb_idx)
    );

    assign done_rise = M_SPI_Done & ~done_q;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch can be inferred.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rx_d    = rx_q;
        tx_d    = tx_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (EN && |REQ) begin
                    state_d = SETUP;
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                    tx_d    = REQ_TxData[arb_idx*DATA_W +: DATA_W];
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            WAIT: begin
                // A done edge on the last timeout cycle still counts as success.
                if (done_rise || cnt_q == TIMEOUT_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = gidx_q;
                    if (done_rise) begin
                        valid_d = 1'b1;
                        rx_d    = M_RxData;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gidx_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            start_q <= start_d;
            done_q  <= M_SPI_Done;
        end
    end

    // Chip selects are derived from the grant so the two can never disagree.
    assign ChipSel_N   = ~gnt_q;
    assign GNT         = gnt_q;
    assign ACK         = ack_q;
    assign RSP_RxData  = rx_q;
    assign RSP_Valid   = valid_q;
    assign RSP_Err     = err_q;
    assign M_StartFlag = start_q;
    assign M_TxData    = tx_q;
    assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus pushes expected responses,
// a monitor checks ACK/response/timing and a master model answers start pulses.
module tb_spi_txn_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int S  = 4;
    localparam int G  = 8;
    localparam int T  = 4096;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] rx;
        bit            valid;
        bit            err;
    } exp_t;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        int            delay;
        bit            hang;
    } mst_t;

    logic            clk, rst_n, en;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_txdata;
    logic [N-1:0]    gnt, ack, cs_n;
    logic [DW-1:0]   rsp_rxdata, m_txdata, m_rxdata;
    logic            rsp_valid, rsp_err, busy, m_start, m_done;

    logic [DW-1:0] words [N];
    exp_t exp_q[$];
    mst_t mst_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, done_cyc = 0;
    int model_ptr = N - 1;
    logic [DW-1:0] last_rx = '0;
    bit tight_gap = 0;

    assign req_txdata = {words[3], words[2], words[1], words[0]};

    spi_txn_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .SETUP_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK_IN(clk), .RST_N(rst_n), .EN(en), .REQ(req), .REQ_TxData(req_txdata),
        .GNT(gnt), .ACK(ack), .RSP_RxData(rsp_rxdata), .RSP_Valid(rsp_valid),
        .RSP_Err(rsp_err), .BUSY(busy), .M_StartFlag(m_start), .M_TxData(m_txdata),
        .M_RxData(m_rxdata), .M_SPI_Done(m_done), .ChipSel_N(cs_n)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference round-robin rule: first set bit searching upward from last winner + 1.
    function automatic int rr_model(input logic [N-1:0] pat, input int ptr);
        for (int k = 1; k <= N; k++)
            if (pat[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic expect_txn(input logic [N-1:0] pat, input bit hang, input int delay,
                              input logic [DW-1:0] rx);
        exp_t e;
        mst_t m;
        int w;
        w = rr_model(pat, model_ptr);
        model_ptr = w;
        e.ack   = N'(1) << w;
        e.valid = !hang;
        e.err   = hang;
        e.rx    = hang ? last_rx : rx;
        if (!hang) last_rx = rx;
        m.tx = words[w];
        m.rx = rx;
        m.delay = delay;
        m.hang = hang;
        exp_q.push_back(e);
        mst_q.push_back(m);
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) words[i] = DW'($urandom);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 0 && n < T + 300);
        if (ack == 0) check("ack_wait_expired", 32'(ack != 0), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_start && n < 200);
        if (!m_start) check("start_wait_expired", 32'(m_start), 1);
    endtask

    // SPI master model: answers each start pulse with a done pulse after the
    // configured delay, or never when the transaction is meant to time out.
    initial begin
        mst_t m;
        m_done = 0;
        m_rxdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m_start) begin
                if (mst_q.size() == 0) begin
                    check("unexpected_start", 32'(m_start), 0);
                end else begin
                    m = mst_q.pop_front();
                    check("m_txdata", m_txdata, m.tx);
                    if (!m.hang) begin
                        repeat (m.delay) @(posedge clk);
                        #1;
                        m_rxdata = m.rx;
                        m_done = 1;
                        done_cyc = cyc;
                        @(posedge clk);
                        #1;
                        m_done = 0;
                    end
                end
            end
        end
    end

    // Monitor: invariants every cycle, grant/start/ACK timing and scoreboard pops.
    initial begin
        logic [N-1:0] prev_gnt, cs_exp;
        logic [3:0]   inv;
        bit prev_ack, prev_start, have_ack;
        int gnt_cyc, start_cyc, ack_cyc, gap;
        exp_t e;
        prev_gnt = '0; prev_ack = 0; prev_start = 0; have_ack = 0;
        gnt_cyc = 0; start_cyc = 0; ack_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gnt = '0; prev_ack = 0; prev_start = 0; have_ack = 0;
            end else begin
                inv = {cs_n == ~gnt, $onehot0(gnt), (gnt == 0) || busy,
                       (ack != 0) || (!rsp_valid && !rsp_err)};
                check("invariants", 32'(inv), 4'hF);
                if (gnt != 0 && prev_gnt == 0) begin
                    gnt_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 32'(gnt), 0);
                    end else begin
                        cs_exp = ~exp_q[0].ack;
                        check("grant_onehot", 32'(gnt), 32'(exp_q[0].ack));
                        check("cs_at_grant", 32'(cs_n), 32'(cs_exp));
                    end
                    if (have_ack) begin
                        gap = cyc - ack_cyc;
                        if (tight_gap) check("gap_exact", gap, G + 1);
                        else check("gap_min", (gap >= G + 1) ? G + 1 : gap, G + 1);
                    end
                end
                if (m_start) begin
                    check("start_latency", cyc - gnt_cyc, S);
                    check("start_single", 32'(prev_start), 0);
                    start_cyc = cyc;
                end
                if (ack != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_onehot", 32'(ack), 32'(e.ack));
                        check("rsp_valid", 32'(rsp_valid), 32'(e.valid));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("rsp_rxdata", rsp_rxdata, e.rx);
                        check("gnt_cleared_at_ack", 32'(gnt), 0);
                        if (e.err) check("timeout_latency", cyc - start_cyc, T);
                        else check("done_to_ack", cyc - done_cyc, 1);
                    end
                    ack_cyc = cyc;
                    have_ack = 1;
                end
                if (prev_ack) check("ack_single", 32'({ack, rsp_valid, rsp_err}), 0);
                prev_gnt = gnt;
                prev_ack = (ack != 0);
                prev_start = m_start;
            end
        end
    end

    initial begin
        rst_n = 0; en = 0; req = '0;
        for (int i = 0; i < N; i++) words[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cs", 32'(cs_n), 4'hF);
        check("reset_outs", 32'({gnt, ack, rsp_valid, rsp_err, busy, m_start}), 0);
        check("reset_data", 32'({rsp_rxdata, m_txdata}), 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk); #1;

        // Single request from requester 2.
        en = 1;
        randomize_words();
        words[2] = 16'hA9A5;
        req = 4'b0100;
        expect_txn(4'b0100, 0, 40, 16'hF0A5);
        wait_ack();

        // Reset in the middle of WAIT aborts without ACK.
        tight_gap = 1;
        req = 4'b0001;
        expect_txn(4'b0001, 1, 0, '0);
        wait_start();
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        req = '0;
        @(negedge clk);
        check("midwait_reset_cs", 32'(cs_n), 4'hF);
        check("midwait_reset_gnt", 32'(gnt), 0);
        check("midwait_reset_rx", rsp_rxdata, 0);
        repeat (3) begin
            @(negedge clk);
            check("midwait_reset_ack", 32'(ack), 0);
        end
        exp_q.delete();
        mst_q.delete();
        model_ptr = N - 1;
        last_rx = '0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("busy_after_reset", 32'(busy), 0);
        @(posedge clk); #1;

        // All requests held: grants rotate 0,1,2,3,0.
        req = 4'b1111;
        randomize_words();
        for (int i = 0; i < 5; i++)
            expect_txn(4'b1111, 0, $urandom_range(1, 50), DW'($urandom));
        for (int i = 0; i < 5; i++) wait_ack();

        // Timeout, then the next requester is served normally.
        req = 4'b0011;
        expect_txn(4'b0011, 1, 0, '0);
        expect_txn(4'b0011, 0, 20, DW'($urandom));
        wait_ack();
        wait_ack();

        // Done edge on the final timeout cycle: success wins.
        req = 4'b1000;
        expect_txn(4'b1000, 0, T - 1, DW'($urandom));
        wait_ack();

        // EN low: requests are ignored.
        en = 0;
        req = 4'b0001;
        repeat (30) @(negedge clk);
        check("en0_no_grant", 32'(gnt), 0);
        check("en0_not_busy", 32'(busy), 0);

        // EN dropped mid-WAIT: transaction completes, no further grants.
        @(posedge clk); #1;
        tight_gap = 0;
        en = 1;
        req = 4'b1111;
        expect_txn(4'b1111, 0, 30, DW'($urandom));
        wait_start();
        @(posedge clk); #1 en = 0;
        wait_ack();
        repeat (40) @(negedge clk);
        check("en_drop_no_grant", 32'(gnt), 0);
        check("en_drop_idle", 32'(busy), 0);
        @(posedge clk); #1;

        // Randomised traffic.
        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] pat;
            tight_gap = (i > 0);
            en = 1;
            pat = N'($urandom_range(1, 15));
            randomize_words();
            req = pat;
            expect_txn(pat, 0, $urandom_range(1, 60), DW'($urandom));
            wait_ack();
        end
        req = '0;
        repeat (20) @(negedge clk);
        check("queues_drained", 32'(exp_q.size() + mst_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
